// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter that launches one requester word at a time across a clock
// boundary using a toggle request / toggle acknowledge handshake.
module cdc_xfer_arbiter #(
   parameter int NREQ        = 4,
   parameter int DW          = 64,
   parameter int HOLD_CYCLES = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic                 src_clk,
   input  logic                 src_rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic                 ack_toggle,
   input  logic                 err_clr,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic [DW-1:0]        xfer_data,
   output logic                 xfer_toggle,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [15:0]          word_count,
   output logic [1:0]           state_dbg
);

   localparam int IW = $clog2(NREQ);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LAUNCH   = 2'd1;
   localparam logic [1:0] ST_WAIT_ACK = 2'd2;
   localparam logic [1:0] ST_SETTLE   = 2'd3;

   localparam logic [IW-1:0]   LAST_RST   = IW'(NREQ - 1);
   localparam logic [15:0]     TIMER_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]      HOLD_LOAD  = 8'(HOLD_CYCLES);
   localparam logic [NREQ-1:0] ONE_HOT0   = NREQ'(1);

   // Handshake: xfer_data is valid from the cycle xfer_toggle flips until the
   // destination echoes the new toggle level on ack_toggle; it is then held for
   // HOLD_CYCLES more cycles before the requester sees done.

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [DW-1:0]   xfer_data_q, xfer_data_d;
   logic            xfer_toggle_q, xfer_toggle_d;
   logic            timeout_err_q, timeout_err_d;
   logic [15:0]     word_count_q, word_count_d;
   logic [IW-1:0]   last_q, last_d;
   logic [15:0]     timer_q, timer_d;
   logic [7:0]      hold_q, hold_d;
   logic            ack_meta_q, ack_meta_d;
   logic            ack_sync_q, ack_sync_d;

   logic [NREQ-1:0] eligible;
   logic            found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;

   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   always_comb begin
      ack_meta_d = ack_toggle;
      ack_sync_d = ack_meta_q;
   end

   // Search starts one past the previous winner; a requester in its done cycle sits out.
   always_comb begin
      eligible = req & ~done_q;
      found    = 1'b0;
      win_idx  = '0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_index(last_q, k);
         if (!found && eligible[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      done_d        = '0;
      xfer_data_d   = xfer_data_q;
      xfer_toggle_d = xfer_toggle_q;
      timeout_err_d = timeout_err_q;
      word_count_d  = word_count_q;
      last_d        = last_q;
      timer_d       = timer_q;
      hold_d        = hold_q;

      case (state_q)
         ST_IDLE: begin
            if (err_clr) begin
               timeout_err_d = 1'b0;
               xfer_toggle_d = ack_sync_q;
            end else if (!timeout_err_q && found) begin
               grant_d     = ONE_HOT0 << win_idx;
               xfer_data_d = req_data[int'(win_idx)*DW +: DW];
               last_d      = win_idx;
               state_d     = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            xfer_toggle_d = ~xfer_toggle_q;
            timer_d       = '0;
            state_d       = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // An ack seen on the timeout boundary still completes the word.
            if (ack_sync_q == xfer_toggle_q) begin
               hold_d  = HOLD_LOAD;
               state_d = ST_SETTLE;
            end else if (timer_q == TIMER_LAST) begin
               timeout_err_d = 1'b1;
               grant_d       = '0;
               state_d       = ST_IDLE;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         ST_SETTLE: begin
            if (hold_q <= 8'd1) begin
               grant_d      = '0;
               done_d       = grant_q;
               word_count_d = word_count_q + 16'd1;
               state_d      = ST_IDLE;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge src_clk) begin
      if (src_rst) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         done_q        <= '0;
         xfer_data_q   <= '0;
         xfer_toggle_q <= 1'b0;
         timeout_err_q <= 1'b0;
         word_count_q  <= '0;
         last_q        <= LAST_RST;
         timer_q       <= '0;
         hold_q        <= '0;
         ack_meta_q    <= 1'b0;
         ack_sync_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         xfer_data_q   <= xfer_data_d;
         xfer_toggle_q <= xfer_toggle_d;
         timeout_err_q <= timeout_err_d;
         word_count_q  <= word_count_d;
         last_q        <= last_d;
         timer_q       <= timer_d;
         hold_q        <= hold_d;
         ack_meta_q    <= ack_meta_d;
         ack_sync_q    <= ack_sync_d;
      end
   end

   always_comb begin
      grant       = grant_q;
      done        = done_q;
      xfer_data   = xfer_data_q;
      xfer_toggle = xfer_toggle_q;
      busy        = (state_q != ST_IDLE);
      timeout_err = timeout_err_q;
      word_count  = word_count_q;
      state_dbg   = state_q;
   end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter: a table of single transfers plus
// hand-timed sequences for contention, timeout, reset, wrap and boundary ack.
module tb_cdc_xfer_arbiter;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] data;
      int          dly;
      logic        drop;
      logic [3:0]  exp_grant;
      logic [63:0] exp_data;
      logic [15:0] exp_wc;
      int          exp_lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // u0: TIMEOUT=16, HOLD_CYCLES=4 with an automatic ack responder
   logic [3:0]   req0 = '0;
   logic [255:0] data0 = '0;
   logic         ack0;
   logic         clr0 = 1'b0;
   logic [3:0]   grant0, done0;
   logic [63:0]  xd0;
   logic         xt0, busy0, terr0;
   logic [15:0]  wc0;
   logic [1:0]   st0;

   // u1: TIMEOUT=4, HOLD_CYCLES=2, ack driven by hand
   logic [3:0]   req1 = '0;
   logic [255:0] data1 = '0;
   logic         ack1 = 1'b0;
   logic         clr1 = 1'b0;
   logic [3:0]   grant1, done1;
   logic [63:0]  xd1;
   logic         xt1, busy1, terr1;
   logic [15:0]  wc1;
   logic [1:0]   st1;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt0 = 0;

   logic [7:0] hist = '0;
   logic       ack_auto = 1'b0;
   logic       ack_hold = 1'b0;
   int         ack_dly = 1;

   logic [3:0] exp_q[$];
   vec_t       vecs[8];

   cdc_xfer_arbiter #(.NREQ(4), .DW(64), .HOLD_CYCLES(4), .TIMEOUT(16)) u0 (
      .src_clk(clk), .src_rst(rst), .req(req0), .req_data(data0),
      .ack_toggle(ack0), .err_clr(clr0), .grant(grant0), .done(done0),
      .xfer_data(xd0), .xfer_toggle(xt0), .busy(busy0), .timeout_err(terr0),
      .word_count(wc0), .state_dbg(st0)
   );

   cdc_xfer_arbiter #(.NREQ(4), .DW(64), .HOLD_CYCLES(2), .TIMEOUT(4)) u1 (
      .src_clk(clk), .src_rst(rst), .req(req1), .req_data(data1),
      .ack_toggle(ack1), .err_clr(clr1), .grant(grant1), .done(done1),
      .xfer_data(xd1), .xfer_toggle(xt1), .busy(busy1), .timeout_err(terr1),
      .word_count(wc1), .state_dbg(st1)
   );

   always #5 clk = ~clk;

   // Destination model: echoes xfer_toggle ack_dly cycles later (1 = immediately).
   always @(posedge clk) begin
      #1;
      hist = {hist[6:0], xt0};
      ack0 = ack_auto ? hist[ack_dly-1] : ack_hold;
   end

   always @(posedge clk) begin
      #2;
      if (done0 != 4'b0) done_cnt0++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; ack_auto = 1'b0; ack_hold = 1'b0; ack1 = 1'b0;
      req0 = '0; req1 = '0; clr0 = 1'b0; clr1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (9) @(negedge clk);
      ack_auto = 1'b1;
   endtask

   task automatic run_xfer(input vec_t v, input string tag);
      int   lat;
      logic stable;
      ack_dly = v.dly;
      @(negedge clk);
      data0 = {v.data ^ 64'd3, v.data ^ 64'd2, v.data ^ 64'd1, v.data};
      req0 = v.req;
      @(negedge clk);
      chk($sformatf("%s.grant", tag), 64'(grant0), 64'(v.exp_grant));
      chk($sformatf("%s.xfer_data", tag), xd0, v.exp_data);
      chk($sformatf("%s.busy", tag), 64'(busy0), 64'd1);
      data0 = ~data0;
      stable = 1'b1;
      lat = 1;
      while (done0 == 4'b0 && lat < 60) begin
         @(negedge clk);
         lat++;
         if (lat == 2 && v.drop) req0 = '0;
         if (xd0 !== v.exp_data) stable = 1'b0;
      end
      chk($sformatf("%s.latency", tag), 64'(lat), 64'(v.exp_lat));
      chk($sformatf("%s.done", tag), 64'(done0), 64'(v.exp_grant));
      chk($sformatf("%s.word_count", tag), 64'(wc0), 64'(v.exp_wc));
      chk($sformatf("%s.grant_clr", tag), 64'(grant0), 64'd0);
      chk($sformatf("%s.data_stable", tag), 64'(stable), 64'd1);
      req0 = '0;
   endtask

   initial begin
      int   cyc;
      int   dones;
      int   snap;
      logic overlap;
      logic bad;
      logic [3:0] prev;
      vec_t v;

      vecs[0] = '{4'b0001, 64'hDEADBEEF_CAFEF00D, 4, 1'b0, 4'b0001, 64'hDEADBEEF_CAFEF00D, 16'd1, 12};
      vecs[1] = '{4'b0010, 64'h01234567_89ABCDEF, 1, 1'b1, 4'b0010, 64'h01234567_89ABCDEE, 16'd2, 9};
      vecs[2] = '{4'b1001, 64'h00000000_00000000, 2, 1'b0, 4'b1000, 64'h00000000_00000003, 16'd3, 10};
      vecs[3] = '{4'b1001, 64'hFFFFFFFF_FFFFFFFF, 3, 1'b0, 4'b0001, 64'hFFFFFFFF_FFFFFFFF, 16'd4, 11};
      vecs[4] = '{4'b0110, 64'hA5A5A5A5_5A5A5A5A, 1, 1'b0, 4'b0010, 64'hA5A5A5A5_5A5A5A5B, 16'd5, 9};
      vecs[5] = '{4'b0110, 64'hA5A5A5A5_5A5A5A5A, 5, 1'b0, 4'b0100, 64'hA5A5A5A5_5A5A5A58, 16'd6, 13};
      vecs[6] = '{4'b1111, 64'h80000000_00000000, 1, 1'b0, 4'b1000, 64'h80000000_00000003, 16'd7, 9};
      vecs[7] = '{4'b0100, 64'h00000000_00001234, 1, 1'b0, 4'b0100, 64'h00000000_00001236, 16'd8, 9};

      // Reset values
      do_reset();
      chk("rst.grant", 64'(grant0), 64'd0);
      chk("rst.done", 64'(done0), 64'd0);
      chk("rst.xfer_data", xd0, 64'd0);
      chk("rst.xfer_toggle", 64'(xt0), 64'd0);
      chk("rst.busy", 64'(busy0), 64'd0);
      chk("rst.timeout_err", 64'(terr0), 64'd0);
      chk("rst.word_count", 64'(wc0), 64'd0);

      // Table of single transfers, round-robin order hand-derived from last_winner
      for (int i = 0; i < 8; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

      // Contention: all four request, each drops after its own done
      do_reset();
      ack_dly = 1;
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
      data0 = {64'h3333, 64'h2222, 64'h1111, 64'h0000};
      @(negedge clk);
      req0 = 4'b1111;
      cyc = 0; dones = 0; overlap = 1'b0; prev = '0;
      while (cyc < 200 && dones < 4) begin
         @(negedge clk);
         cyc++;
         if ($countones(grant0) > 1) overlap = 1'b1;
         if (grant0 != 4'b0 && grant0 != prev) begin
            if (exp_q.size() > 0) chk("cont.grant_order", 64'(grant0), 64'(exp_q.pop_front()));
            else chk("cont.extra_grant", 64'(grant0), 64'd0);
         end
         if (done0 != 4'b0) begin
            dones++;
            req0 = req0 & ~done0;
         end
         prev = grant0;
      end
      snap = done_cnt0;
      repeat (12) @(negedge clk);
      chk("cont.done_count", 64'(dones), 64'd4);
      chk("cont.no_extra_done", 64'(done_cnt0 - snap), 64'd0);
      chk("cont.overlap", 64'(overlap), 64'd0);
      chk("cont.queue_empty", 64'(exp_q.size()), 64'd0);

      // Timeout: ack held low, 16 WAIT_ACK cycles then sticky error
      do_reset();
      ack_auto = 1'b0; ack_hold = 1'b0;
      snap = done_cnt0;
      @(negedge clk);
      data0 = {64'h0, 64'h0, 64'h0, 64'h0BAD_0BAD_0BAD_0BAD};
      req0 = 4'b0001;
      repeat (17) @(negedge clk);
      chk("tmo.err_before", 64'(terr0), 64'd0);
      chk("tmo.busy_before", 64'(busy0), 64'd1);
      @(negedge clk);
      chk("tmo.err_set", 64'(terr0), 64'd1);
      chk("tmo.grant_clr", 64'(grant0), 64'd0);
      chk("tmo.busy_clr", 64'(busy0), 64'd0);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (grant0 != 4'b0 || busy0) bad = 1'b1;
      end
      chk("tmo.req_ignored", 64'(bad), 64'd0);
      chk("tmo.no_done", 64'(done_cnt0 - snap), 64'd0);
      req0 = '0;
      @(negedge clk);
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      chk("tmo.err_cleared", 64'(terr0), 64'd0);
      chk("tmo.toggle_realign", 64'(xt0), 64'd0);
      repeat (9) @(negedge clk);
      ack_auto = 1'b1;
      v = '{4'b0001, 64'h0000_1111_2222_3333, 1, 1'b0, 4'b0001, 64'h0000_1111_2222_3333, 16'd1, 9};
      run_xfer(v, "tmo.recover");

      // Reset in the middle of WAIT_ACK
      ack_hold = ack0;
      ack_auto = 1'b0;
      snap = done_cnt0;
      @(negedge clk);
      data0 = {64'h0, 64'h0, 64'h7777_6666_5555_4444, 64'h0};
      req0 = 4'b0010;
      repeat (2) @(negedge clk);
      chk("mrst.in_wait", 64'(st0), 64'd2);
      rst = 1'b1; ack_hold = 1'b0;
      @(negedge clk);
      chk("mrst.grant", 64'(grant0), 64'd0);
      chk("mrst.done", 64'(done0), 64'd0);
      chk("mrst.xfer_data", xd0, 64'd0);
      chk("mrst.xfer_toggle", 64'(xt0), 64'd0);
      chk("mrst.busy", 64'(busy0), 64'd0);
      chk("mrst.word_count", 64'(wc0), 64'd0);
      rst = 1'b0; req0 = '0;
      repeat (9) @(negedge clk);
      chk("mrst.no_done", 64'(done_cnt0 - snap), 64'd0);
      ack_auto = 1'b1;
      v = '{4'b0010, 64'h7777_6666_5555_4444, 1, 1'b0, 4'b0010, 64'h7777_6666_5555_4445, 16'd1, 9};
      run_xfer(v, "mrst.after");
      chk("mrst.toggle_one", 64'(xt0), 64'd1);

      // word_count wrap from 0xFFFF
      @(negedge clk);
      force u0.word_count_q = 16'hFFFF;
      @(negedge clk);
      release u0.word_count_q;
      v = '{4'b0001, 64'h0F0F_0F0F_0F0F_0F0F, 1, 1'b0, 4'b0001, 64'h0F0F_0F0F_0F0F_0F0F, 16'h0000, 9};
      run_xfer(v, "wrap");

      // Requester held through its own done is skipped for that one cycle
      ack_dly = 1;
      @(negedge clk);
      req0 = 4'b0100;
      cyc = 0;
      while (done0 == 4'b0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("hold.done", 64'(done0), 64'b0100);
      @(negedge clk);
      chk("hold.skip_done_cycle", 64'(grant0), 64'd0);
      @(negedge clk);
      chk("hold.regrant", 64'(grant0), 64'b0100);
      req0 = '0;
      cyc = 0;
      while (done0 == 4'b0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("hold.word_count", 64'(wc0), 64'd2);

      // Ack match on the same cycle the timer expires (TIMEOUT=4)
      do_reset();
      @(negedge clk);
      data1 = {64'h0, 64'h0, 64'h0, 64'h5555_AAAA_0000_FFFF};
      req1 = 4'b0001;
      repeat (3) @(negedge clk);
      ack1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("edge.still_wait", 64'(st1), 64'd2);
      @(negedge clk);
      chk("edge.settle", 64'(st1), 64'd3);
      chk("edge.err_low", 64'(terr1), 64'd0);
      repeat (2) @(negedge clk);
      chk("edge.done", 64'(done1), 64'b0001);
      chk("edge.word_count", 64'(wc1), 64'd1);
      chk("edge.err_final", 64'(terr1), 64'd0);
      chk("edge.xfer_data", xd1, 64'h5555_AAAA_0000_FFFF);
      req1 = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cdc_xfer_arbiter.md
CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DW, default 64, SHALL set the transferred word width.
REQ-003 Parameter HOLD_CYCLES, default 4, SHALL set the post-ack data hold time in cycles (1..255).
REQ-004 Parameter TIMEOUT, default 1023, SHALL set the maximum WAIT_ACK cycles (1..65535).
REQ-005 src_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 src_rst  in  1  SHALL be the reset: synchronous and active-high.
REQ-007 req  in  NREQ  SHALL carry per-requester request levels, held until the matching done.
REQ-008 req_data  in  NREQ*DW  SHALL carry requester i's word at bits [i*DW +: DW].
REQ-009 ack_toggle  in  1  SHALL be the asynchronous destination acknowledge, flipping once per received word.
REQ-010 err_clr  in  1  SHALL clear timeout_err and realign the toggle handshake.
REQ-011 grant  out  NREQ  SHALL be one-hot, marking the requester being served.
REQ-012 done  out  NREQ  SHALL pulse for one cycle when requester i's word completes.
REQ-013 xfer_data  out  DW  SHALL drive the data-crossing input.
REQ-014 xfer_toggle  out  1  SHALL flip once per launched word.
REQ-015 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-016 timeout_err  out  1  SHALL be a sticky timeout flag.
REQ-017 word_count  out  16  SHALL count completed transfers.

Function
REQ-018 ack_toggle SHALL pass through a two-flop synchronizer, giving ack_sync, before any use.
REQ-019 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_ACK and SETTLE.
REQ-020 IDLE: if timeout_err=0 and any eligible req is high, the block SHALL select a winner, register xfer_data<=req_data[w] and grant<=onehot(w), and go to LAUNCH on the next cycle.
REQ-021 Arbitration SHALL be round-robin: the search starts at last_winner+1 mod NREQ, and last_winner resets to NREQ-1 so requester 0 wins first.
REQ-022 A requester whose done is high in the current cycle SHALL be ineligible in that cycle.
REQ-023 LAUNCH SHALL last exactly one cycle: flip xfer_toggle, clear the timeout timer, then go to WAIT_ACK.
REQ-024 WAIT_ACK: when ack_sync==xfer_toggle, the block SHALL load the hold counter with HOLD_CYCLES and go to SETTLE.
REQ-025 WAIT_ACK: when the timer reaches TIMEOUT with no match, the block SHALL set timeout_err, clear grant, assert no done, and go to IDLE.
REQ-026 If ack match and timeout occur in the same cycle, the ack match SHALL win.
REQ-027 SETTLE SHALL last exactly HOLD_CYCLES cycles, then go to IDLE.
REQ-028 On the SETTLE->IDLE transition the block SHALL clear grant, pulse done[w] for one cycle, and increment word_count (wrapping 0xFFFF->0x0000).
REQ-029 xfer_data SHALL remain stable from the LAUNCH cycle through the last SETTLE cycle; it holds its last value while IDLE.
REQ-030 While timeout_err=1 no new transfer SHALL launch.
REQ-031 err_clr in IDLE SHALL clear timeout_err and set xfer_toggle<=ack_sync in that cycle; err_clr outside IDLE SHALL be ignored.
REQ-032 A req dropped mid-transfer SHALL NOT abort it; the transfer completes and done still pulses.
REQ-033 Minimum latency, req rising to done, SHALL be 1 (grant) + 1 (LAUNCH) + 2 (sync) + HOLD_CYCLES + 1 cycles for an immediate destination ack.

Reset
REQ-034 src_rst=1 SHALL force state=IDLE, grant=0, done=0, xfer_data=0, xfer_toggle=0, ack sync flops=0, busy=0, timeout_err=0, word_count=0, last_winner=NREQ-1, timers=0.
REQ-035 Reset SHALL take effect in any state, including mid-transfer, and SHALL discard the in-flight word without a done.

Verification
REQ-036 Single request: req=0001, data0=0xDEADBEEF_CAFEF00D, ack echoes 3 cycles after the toggle -> xfer_data holds 0xDEADBEEF_CAFEF00D; done[0] pulses once; word_count=1.
REQ-037 Contention: req=1111 held, each requester dropping after its own done -> grant order 0,1,2,3; exactly four done pulses; no two grant bits high together.
REQ-038 Timeout: TIMEOUT=16, ack_toggle held at 0 -> timeout_err=1 after 16 WAIT_ACK cycles; no done; later req ignored; err_clr then req -> normal transfer completes.
REQ-039 Reset mid-WAIT_ACK -> all outputs at reset values the next cycle; a subsequent transfer completes normally with xfer_toggle=1.
REQ-040 Wrap: word_count preloaded by 65535 transfers, then one more -> word_count=0x0000.
REQ-041 Same-cycle timeout and ack match (TIMEOUT=4, ack arriving exactly on the boundary) -> SETTLE entered; done pulses; timeout_err stays 0.
